uart_mmio: RTL and testbench

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio.sv | 198 +++++++++++++++++++
 tb/tb_uart_mmio.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with DATA/STATUS registers.
// Define UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register.
module uart_mmio #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [7:0]  wdata_i,
  output logic [31:0] rdata_o,
  output logic        rd_ack_o,
  output logic        txd_o,
  input  logic        rxd_i
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic rd, wr, stat_clr, pop, push, push_ok, full, frame_bad, ovr_set;
  logic tx_ready, rx_valid, overrun, frame_err;
  logic [7:0] rx_head;

  assign rd       = sel_i & ~we_i;
  assign stat_clr = rd & addr_i;
  assign pop      = rd & ~addr_i & rx_valid;
  assign wr       = sel_i & we_i & ~addr_i & tx_ready;
  assign rdata_o  = addr_i ? {28'd0, frame_err, overrun, rx_valid, tx_ready}
                           : {24'd0, rx_valid ? rx_head : 8'd0};

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ack_o  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_ack_o  <= rd;
      overrun   <= (overrun & ~stat_clr) | ovr_set;
      frame_err <= (frame_err & ~stat_clr) | frame_bad;
    end

  state_t tx_state, tx_next;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
    end

  always_comb begin
    tx_next  = tx_state;
    tx_cnt_n = tx_cnt + CW'(1);
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (wr) begin
          tx_next = START;
          tx_sh_n = wdata_i;
        end
      end
      START: if (tx_cnt == LAST) begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        tx_next  = DATA;
      end
      DATA: if (tx_cnt == LAST) begin
        tx_cnt_n = '0;
        tx_sh_n  = tx_sh >> 1;
        tx_bit_n = tx_bit + 3'd1;
        tx_next  = tx_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (tx_cnt == LAST) begin
        tx_cnt_n = '0;
        tx_next  = IDLE;
      end
    endcase
  end

  assign tx_ready = tx_state == IDLE;
  assign txd_o    = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;

  state_t rx_state, rx_next;
  logic [1:0] sync;
  logic rx_s, rx_prev;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync     <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      sync     <= {sync[0], rxd_i};
      rx_prev  <= rx_s;
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end

  // START waits half a bit so every later sample lands mid-bit
  always_comb begin
    rx_next   = rx_state;
    rx_cnt_n  = rx_cnt + CW'(1);
    rx_bit_n  = rx_bit;
    rx_sh_n   = rx_sh;
    push      = 1'b0;
    frame_bad = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev & ~rx_s) rx_next = START;
      end
      START: if (rx_cnt == HALF) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_next  = rx_s ? IDLE : DATA;
      end
      DATA: if (rx_cnt == LAST) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s, rx_sh[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        rx_next  = rx_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (rx_cnt == LAST) begin
        rx_cnt_n  = '0;
        push      = rx_s;
        frame_bad = ~rx_s;
        rx_next   = IDLE;
      end
    endcase
  end

  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;

  assign full     = cnt == 3'd4;
  assign rx_valid = cnt != 3'd0;
  assign rx_head  = mem[rp];

  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= rx_sh;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + {1'b0, push_ok};
      rp  <= rp + {1'b0, pop};
      cnt <= cnt + {2'd0, push_ok} - {2'd0, pop};
    end
`else
  logic [7:0] hold;

  assign full    = rx_valid;
  assign rx_head = hold;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold     <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (push_ok) hold <= rx_sh;
      rx_valid <= push_ok | (rx_valid & ~pop);
    end
`endif
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio at CLKS_PER_BIT=16.
module tb_uart_mmio;
  logic clk = 1'b0, rst = 1'b0, sel_i = 1'b0, we_i = 1'b0, addr_i = 1'b0, rxd_i = 1'b1;
  logic [7:0] wdata_i = 8'd0;
  logic [31:0] rdata_o;
  logic rd_ack_o, txd_o;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic exp_ovr = 1'b0, exp_ferr = 1'b0;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  always #5 clk = ~clk;

  uart_mmio #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rd_ack_o(rd_ack_o),
    .txd_o(txd_o), .rxd_i(rxd_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1 d = rdata_o;
    @(posedge clk);
    #1 sel_i = 1'b0;
    check("rd_ack", {31'd0, rd_ack_o}, 32'd1);
    @(posedge clk);
    #1 check("rd_ack_off", {31'd0, rd_ack_o}, 32'd0);
  endtask

  task automatic check_status();
    logic [31:0] d;
    bus_read(1'b1, d);
    check("status", d, {28'd0, exp_ferr, exp_ovr, exp_q.size() != 0, 1'b1});
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  task automatic read_data();
    logic [31:0] d;
    bus_read(1'b0, d);
    if (exp_q.size() == 0) check("data_empty", d, 32'd0);
    else check("data", d, {24'd0, exp_q.pop_front()});
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    if (!stop) exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
    @(negedge clk);
    rxd_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (16) @(negedge clk);
    end
    rxd_i = stop;
    repeat (16) @(negedge clk);
    rxd_i = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic start_write(input logic [7:0] b);
    @(negedge clk);
    sel_i = 1'b1; we_i = 1'b1; addr_i = 1'b0; wdata_i = b;
    @(posedge clk);
    #1 sel_i = 1'b0; we_i = 1'b0; addr_i = 1'b1;
    #1;
  endtask

  task automatic tx_frame(input logic [7:0] b);
    logic e;
    start_write(b);
    for (int i = 0; i <= 160; i++) begin
      e = i < 16 ? 1'b0 : i < 144 ? b[(i - 16) / 16] : 1'b1;
      check("tx", {30'd0, txd_o, rdata_o[0]}, {30'd0, e, i == 160});
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    addr_i = 1'b1;
    #1;
    check("rst_txd", {31'd0, txd_o}, 32'd1);
    check("rst_ack", {31'd0, rd_ack_o}, 32'd0);
    check("rst_status", rdata_o, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    tx_frame(8'hA5);

    send_rx(8'h3C, 1'b1);
    check_status();
    read_data();
    check_status();

    @(negedge clk);
    rxd_i = 1'b0;
    repeat (5) @(negedge clk);
    rxd_i = 1'b1;
    repeat (40) @(negedge clk);
    check_status();
    read_data();

    send_rx(8'h11, 1'b0);
    check_status();
    check_status();

    for (int k = 1; k <= DEPTH + 1; k++) send_rx(8'(k), 1'b1);
    check_status();
    while (exp_q.size() != 0) read_data();
    read_data();
    check_status();

    fork
      tx_frame(8'h96);
      send_rx(8'h69, 1'b1);
    join
    read_data();

    start_write(8'h5A);
    repeat (72) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_txd", {31'd0, txd_o}, 32'd1);
    check("abort_ready", {31'd0, rdata_o[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    check_status();
    tx_frame(8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
